// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants and state type for the 40-tap FIR MAC reader
package fir_pkg;
    localparam int NUM_TAPS       = 40;
    localparam int TAPS_PER_PHASE = 4;
    localparam int NUM_PHASES     = 10;
    localparam int TAP_W          = 3;
    localparam int COEF_W         = 16;
    localparam int ACC_W          = TAP_W + COEF_W + 6;
    localparam int PHASE_W        = 4;
    localparam int ADDR_W         = 6;

    typedef enum logic {
        IDLE = 1'b0,
        MAC  = 1'b1
    } state_t;
endpackage

// File: rtl/fir_coef_bank.sv
// rtl/fir_coef_bank.sv - 40-entry signed coefficient register file, one write port, four phase-indexed read ports
module fir_coef_bank #(
    parameter int COEF_W = fir_pkg::COEF_W
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   wr_en,
    input  logic [fir_pkg::ADDR_W-1:0]             wr_addr,
    input  logic [COEF_W-1:0]                      wr_data,
    input  logic [fir_pkg::PHASE_W-1:0]            phase,
    output logic [fir_pkg::TAPS_PER_PHASE-1:0][COEF_W-1:0] rd_data
);
    import fir_pkg::*;

    logic [COEF_W-1:0] coef [NUM_TAPS];
    logic [ADDR_W-1:0] base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                coef[i] <= '0;
            end
        end else if (wr_en) begin
            coef[wr_addr] <= wr_data;
        end
    end

    assign base = {phase, 2'b00};

    always_comb begin
        for (int j = 0; j < TAPS_PER_PHASE; j++) begin
            rd_data[j] = coef[base + ADDR_W'(j)];
        end
    end
endmodule

// File: rtl/fir_tap_mac.sv
// rtl/fir_tap_mac.sv - snapshots 40 delay taps and accumulates them against programmable coefficients, four taps per clock
module fir_tap_mac #(
    parameter int WIDTH  = 3,
    parameter int COEF_W = fir_pkg::COEF_W,
    parameter int ACC_W  = WIDTH + COEF_W + 6
) (
    input  logic                        iClk12M,
    input  logic                        iRsn,
    input  logic                        iEnMac,
    input  logic [WIDTH-1:0]            iDelay1,  iDelay2,  iDelay3,  iDelay4,  iDelay5,
    input  logic [WIDTH-1:0]            iDelay6,  iDelay7,  iDelay8,  iDelay9,  iDelay10,
    input  logic [WIDTH-1:0]            iDelay11, iDelay12, iDelay13, iDelay14, iDelay15,
    input  logic [WIDTH-1:0]            iDelay16, iDelay17, iDelay18, iDelay19, iDelay20,
    input  logic [WIDTH-1:0]            iDelay21, iDelay22, iDelay23, iDelay24, iDelay25,
    input  logic [WIDTH-1:0]            iDelay26, iDelay27, iDelay28, iDelay29, iDelay30,
    input  logic [WIDTH-1:0]            iDelay31, iDelay32, iDelay33, iDelay34, iDelay35,
    input  logic [WIDTH-1:0]            iDelay36, iDelay37, iDelay38, iDelay39, iDelay40,
    input  logic                        iCoefWr,
    input  logic [fir_pkg::ADDR_W-1:0]  iCoefAddr,
    input  logic [COEF_W-1:0]           iCoefData,
    output logic [ACC_W-1:0]            oFirOut,
    output logic                        oValid,
    output logic                        oBusy
);
    import fir_pkg::*;

    state_t                                    state, state_nxt;
    logic [PHASE_W-1:0]                        phase;
    logic [NUM_TAPS-1:0][WIDTH-1:0]            taps, snap;
    logic [TAPS_PER_PHASE-1:0][COEF_W-1:0]     coef_rd;
    logic signed [WIDTH+COEF_W-1:0]            prod [TAPS_PER_PHASE];
    logic signed [ACC_W-1:0]                   phase_sum, acc;
    logic [ADDR_W-1:0]                         base;
    logic                                      coef_wr_en;
    logic                                      last_phase;

    assign taps = {iDelay40, iDelay39, iDelay38, iDelay37, iDelay36, iDelay35, iDelay34, iDelay33,
                   iDelay32, iDelay31, iDelay30, iDelay29, iDelay28, iDelay27, iDelay26, iDelay25,
                   iDelay24, iDelay23, iDelay22, iDelay21, iDelay20, iDelay19, iDelay18, iDelay17,
                   iDelay16, iDelay15, iDelay14, iDelay13, iDelay12, iDelay11, iDelay10, iDelay9,
                   iDelay8,  iDelay7,  iDelay6,  iDelay5,  iDelay4,  iDelay3,  iDelay2,  iDelay1};

    // oBusy tracks the MAC state exactly, so it doubles as the write lockout
    assign coef_wr_en = iCoefWr && !oBusy && (iCoefAddr < ADDR_W'(NUM_TAPS));
    assign last_phase = (phase == PHASE_W'(NUM_PHASES - 1));
    assign base       = {phase, 2'b00};

    fir_coef_bank #(.COEF_W(COEF_W)) u_coef_bank (
        .clk     (iClk12M),
        .rst_n   (iRsn),
        .wr_en   (coef_wr_en),
        .wr_addr (iCoefAddr),
        .wr_data (iCoefData),
        .phase   (phase),
        .rd_data (coef_rd)
    );

    always_comb begin
        phase_sum = '0;
        for (int j = 0; j < TAPS_PER_PHASE; j++) begin
            prod[j]   = $signed(snap[base + ADDR_W'(j)]) * $signed(coef_rd[j]);
            phase_sum = phase_sum + ACC_W'(prod[j]);
        end
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (iEnMac) state_nxt = MAC;
            MAC:     if (last_phase) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            phase   <= '0;
            snap    <= '0;
            acc     <= '0;
            oFirOut <= '0;
            oValid  <= 1'b0;
            oBusy   <= 1'b0;
        end else begin
            oValid <= 1'b0;
            if (state == IDLE) begin
                if (iEnMac) begin
                    snap  <= taps;
                    acc   <= '0;
                    phase <= '0;
                    oBusy <= 1'b1;
                end
            end else begin
                acc <= acc + phase_sum;
                if (last_phase) begin
                    oFirOut <= acc + phase_sum;
                    oValid  <= 1'b1;
                    oBusy   <= 1'b0;
                    phase   <= '0;
                end else begin
                    phase <= phase + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fir_tap_mac.sv
// tb/tb_fir_tap_mac.sv - randomized self-checking bench for fir_tap_mac against an integer dot-product model
module tb_fir_tap_mac;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        coef_wr;
    logic [5:0]  coef_addr;
    logic [15:0] coef_data;
    logic [2:0]  dly [40];
    logic [24:0] fir_out;
    logic        valid;
    logic        busy;

    int          model_coef [40];
    int          checks = 0;
    int          errors = 0;

    logic [14:0] busy_mask;
    int          valid_cnt;
    int          valid_cyc;
    logic [24:0] res;

    always #5 clk = ~clk;

    fir_tap_mac dut (
        .iClk12M(clk), .iRsn(rst_n), .iEnMac(en),
        .iDelay1(dly[0]),   .iDelay2(dly[1]),   .iDelay3(dly[2]),   .iDelay4(dly[3]),
        .iDelay5(dly[4]),   .iDelay6(dly[5]),   .iDelay7(dly[6]),   .iDelay8(dly[7]),
        .iDelay9(dly[8]),   .iDelay10(dly[9]),  .iDelay11(dly[10]), .iDelay12(dly[11]),
        .iDelay13(dly[12]), .iDelay14(dly[13]), .iDelay15(dly[14]), .iDelay16(dly[15]),
        .iDelay17(dly[16]), .iDelay18(dly[17]), .iDelay19(dly[18]), .iDelay20(dly[19]),
        .iDelay21(dly[20]), .iDelay22(dly[21]), .iDelay23(dly[22]), .iDelay24(dly[23]),
        .iDelay25(dly[24]), .iDelay26(dly[25]), .iDelay27(dly[26]), .iDelay28(dly[27]),
        .iDelay29(dly[28]), .iDelay30(dly[29]), .iDelay31(dly[30]), .iDelay32(dly[31]),
        .iDelay33(dly[32]), .iDelay34(dly[33]), .iDelay35(dly[34]), .iDelay36(dly[35]),
        .iDelay37(dly[36]), .iDelay38(dly[37]), .iDelay39(dly[38]), .iDelay40(dly[39]),
        .iCoefWr(coef_wr), .iCoefAddr(coef_addr), .iCoefData(coef_data),
        .oFirOut(fir_out), .oValid(valid), .oBusy(busy)
    );

    function automatic int model_out();
        int s = 0;
        for (int k = 0; k < 40; k++) begin
            s += int'($signed(dly[k])) * model_coef[k];
        end
        return s;
    endfunction

    task automatic set_taps(input logic [2:0] v);
        for (int k = 0; k < 40; k++) dly[k] = v;
    endtask

    task automatic write_coef(input logic [5:0] addr, input logic [15:0] data);
        coef_wr = 1'b1; coef_addr = addr; coef_data = data;
        @(posedge clk);
        @(negedge clk);
        coef_wr = 1'b0;
        if (addr < 40) model_coef[addr] = int'($signed(data));
    endtask

    // Starts one sample and records 14 cycles of outputs; cycle c is the c-th negedge after the start edge.
    task automatic run_sample(input bit disturb, input bit wr_start);
        busy_mask = '0; valid_cnt = 0; valid_cyc = 0; res = '0;
        en = 1'b1;
        if (wr_start) coef_wr = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) begin en = 1'b0; coef_wr = 1'b0; end
            busy_mask[c] = busy;
            if (valid) begin valid_cnt++; valid_cyc = c; res = fir_out; end
            if (disturb && c == 3) begin
                en = 1'b1;
                for (int k = 0; k < 40; k++) dly[k] = 3'($urandom);
                coef_wr = 1'b1; coef_addr = 6'd0; coef_data = 16'd100;
            end
            if (disturb && c == 4) begin en = 1'b0; coef_wr = 1'b0; end
        end
    endtask

    task automatic check_run(input string name, input int exp);
        logic [24:0] e;
        e = 25'(exp);
        checks++;
        if (res !== e) begin errors++; $display("FAIL %s result: got %0d expected %0d", name, $signed(res), exp); end
        checks++;
        if (valid_cnt !== 1 || valid_cyc !== 11) begin
            errors++; $display("FAIL %s valid: got %0d pulses at cycle %0d expected 1 at cycle 11", name, valid_cnt, valid_cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; coef_wr = 1'b0; coef_addr = '0; coef_data = '0;
        set_taps(3'd0);
        for (int k = 0; k < 40; k++) model_coef[k] = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (fir_out !== 25'd0 || valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: got out=%0d valid=%b busy=%b expected 0 0 0", fir_out, valid, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        set_taps(3'd1);
        run_sample(1'b0, 1'b0);
        check_run("zero_coef", 0);
    endtask

    task automatic test_ones();
        for (int k = 0; k < 40; k++) write_coef(6'(k), 16'd1);
        set_taps(3'd1);
        run_sample(1'b0, 1'b0);
        check_run("ones", model_out());
        checks++;
        if (busy_mask !== 15'h07FE) begin errors++; $display("FAIL ones_busy: got %b expected %b", busy_mask, 15'h07FE); end
        checks++;
        if (fir_out !== 25'd40 || valid !== 1'b0) begin
            errors++; $display("FAIL ones_hold: got out=%0d valid=%b expected 40 0", fir_out, valid);
        end
    endtask

    task automatic test_impulse();
        for (int k = 0; k < 40; k++) write_coef(6'(k), 16'(k + 1));
        set_taps(3'd0);
        dly[6] = 3'b111;
        run_sample(1'b0, 1'b0);
        check_run("impulse", -7);
    endtask

    task automatic test_extremes();
        for (int k = 0; k < 40; k++) write_coef(6'(k), 16'h8000);
        set_taps(3'b100);
        run_sample(1'b0, 1'b0);
        check_run("extreme_neg", 5242880);
        for (int k = 0; k < 40; k++) write_coef(6'(k), 16'h7FFF);
        set_taps(3'd3);
        run_sample(1'b0, 1'b0);
        check_run("extreme_pos", 3932040);
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            for (int k = 0; k < 40; k++) begin
                write_coef(6'(k), 16'($urandom));
                dly[k] = 3'($urandom);
            end
            write_coef(6'(40 + $urandom_range(0, 23)), 16'($urandom));
            coef_addr = 6'($urandom_range(0, 39));
            coef_data = 16'($urandom);
            model_coef[coef_addr] = int'($signed(coef_data));
            run_sample(1'b0, 1'b1);
            check_run("random_wr_with_start", model_out());
        end
    endtask

    task automatic test_disturb();
        int exp;
        int c0;
        for (int k = 0; k < 40; k++) dly[k] = 3'($urandom);
        exp = model_out();
        c0 = model_coef[0];
        run_sample(1'b1, 1'b0);
        check_run("disturb", exp);
        set_taps(3'd0);
        dly[0] = 3'd1;
        run_sample(1'b0, 1'b0);
        check_run("coef0_readback", c0);
    endtask

    task automatic test_back_to_back();
        int exp;
        int vcyc [$];
        logic [24:0] vres [$];
        for (int k = 0; k < 40; k++) dly[k] = 3'($urandom);
        exp = model_out();
        en = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            en = 1'b0;
            if (valid) begin vcyc.push_back(c); vres.push_back(fir_out); end
            if (c == 11) en = 1'b1;
        end
        checks++;
        if (vcyc.size() !== 2) begin
            errors++; $display("FAIL b2b_count: got %0d pulses expected 2", vcyc.size());
        end else begin
            checks++;
            if (vcyc[0] !== 11 || vcyc[1] !== 22) begin
                errors++; $display("FAIL b2b_timing: got cycles %0d,%0d expected 11,22", vcyc[0], vcyc[1]);
            end
            checks++;
            if (vres[0] !== 25'(exp) || vres[1] !== 25'(exp)) begin
                errors++; $display("FAIL b2b_result: got %0d,%0d expected %0d", $signed(vres[0]), $signed(vres[1]), exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        int vc = 0;
        for (int k = 0; k < 40; k++) dly[k] = 3'($urandom_range(1, 3));
        en = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            en = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || fir_out !== 25'd0) begin
            errors++; $display("FAIL reset_mid: got busy=%b valid=%b out=%0d expected 0 0 0", busy, valid, fir_out);
        end
        for (int k = 0; k < 40; k++) model_coef[k] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (valid) vc++;
        end
        checks++;
        if (vc !== 0) begin errors++; $display("FAIL reset_mid_no_pulse: got %0d pulses expected 0", vc); end
        set_taps(3'd1);
        run_sample(1'b0, 1'b0);
        check_run("after_reset_cleared", model_out());
    endtask

    initial begin
        test_reset();
        test_ones();
        test_impulse();
        test_extremes();
        test_random();
        test_disturb();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
